// File: rtl/imem_loader_pkg.sv
// Shared MIPS system constants and the program-loader state encoding.
// Memory map values are common to the CPU memories, the loader and the bench.
package mips_pkg;

    localparam logic [31:0] INSTADDR  = 32'h0040_0000;
    localparam int          INSTSIZE  = 4096;
    localparam logic [31:0] DATAADDR  = 32'h1001_0000;
    localparam int          DATASIZE  = 4096;
    localparam logic [7:0]  FILL_BYTE = 8'hFF;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        IDLE  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } loader_state_t;

endpackage

// File: rtl/imem_loader_if.sv
// Instruction-word stream into the program loader (valid/ready with last marker).
interface imem_loader_if;

    logic        s_valid;
    logic [31:0] s_word;
    logic        s_last;
    logic        s_ready;

    modport master (
        output s_valid,
        output s_word,
        output s_last,
        input  s_ready
    );

    modport slave (
        input  s_valid,
        input  s_word,
        input  s_last,
        output s_ready
    );

endinterface

// File: rtl/imem_loader.sv
// Program loader: pre-fills instruction memory, streams words in little-endian
// byte writes, then releases the CPU from reset.
//
//   state | meaning
//   FILL  | writing FILL_BYTE to every byte of instruction memory
//   IDLE  | ready for the next instruction word
//   WRITE | emitting the four bytes of the captured word
//   DONE  | program loaded, CPU running; held until reset
module imem_loader #(
    parameter logic [31:0] INSTADDR  = mips_pkg::INSTADDR,
    parameter int          INSTSIZE  = mips_pkg::INSTSIZE,
    parameter logic [7:0]  FILL_BYTE = mips_pkg::FILL_BYTE
) (
    input  logic         CLK,
    input  logic         reset,
    imem_loader_if.slave s,
    output logic         mem_we,
    output logic [31:0]  mem_addr,
    output logic [7:0]   mem_wdata,
    output logic         cpu_reset,
    output logic         done,
    output logic         err
);

    import mips_pkg::loader_state_t;
    import mips_pkg::FILL;
    import mips_pkg::IDLE;
    import mips_pkg::WRITE;
    import mips_pkg::DONE;

    localparam int BCW = $clog2(INSTSIZE);
    localparam int NW  = $clog2(INSTSIZE / 4) + 1;

    localparam logic [BCW-1:0] BC_LAST = BCW'(INSTSIZE - 1);
    localparam logic [NW-1:0]  N_FULL  = NW'(INSTSIZE / 4);

    loader_state_t  state;
    logic [BCW-1:0] bc;
    logic [NW-1:0]  n;
    logic [31:0]    word_q;
    logic           last_q;
    logic [1:0]     b_nxt;
    logic           handshake;

    assign b_nxt     = bc[1:0] + 2'd1;
    assign handshake = s.s_valid & s.s_ready;

    // Outputs are registered together with the state, so each register holds
    // what the bus shows in the cycle the state is current.
    always_ff @(posedge CLK) begin
        if (reset) begin
            state     <= FILL;
            bc        <= '0;
            n         <= '0;
            word_q    <= '0;
            last_q    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= INSTADDR;
            mem_wdata <= FILL_BYTE;
            s.s_ready <= 1'b0;
            cpu_reset <= 1'b1;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            case (state)
                FILL: begin
                    if (!mem_we) begin
                        mem_we <= 1'b1;
                    end else if (bc == BC_LAST) begin
                        mem_we    <= 1'b0;
                        s.s_ready <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        bc       <= bc + 1'b1;
                        mem_addr <= mem_addr + 32'd1;
                    end
                end

                IDLE: begin
                    if (handshake) begin
                        if (n == N_FULL) begin
                            // Memory is full: swallow the word, flag it, never write.
                            err <= 1'b1;
                            if (s.s_last) begin
                                s.s_ready <= 1'b0;
                                cpu_reset <= 1'b0;
                                done      <= 1'b1;
                                state     <= DONE;
                            end
                        end else begin
                            word_q    <= s.s_word;
                            last_q    <= s.s_last;
                            s.s_ready <= 1'b0;
                            bc        <= '0;
                            mem_we    <= 1'b1;
                            mem_addr  <= INSTADDR + (32'(n) << 2);
                            mem_wdata <= s.s_word[7:0];
                            state     <= WRITE;
                        end
                    end
                end

                WRITE: begin
                    if (bc[1:0] == 2'd3) begin
                        mem_we <= 1'b0;
                        n      <= n + 1'b1;
                        if (last_q) begin
                            cpu_reset <= 1'b0;
                            done      <= 1'b1;
                            state     <= DONE;
                        end else begin
                            s.s_ready <= 1'b1;
                            state     <= IDLE;
                        end
                    end else begin
                        bc        <= bc + 1'b1;
                        mem_addr  <= mem_addr + 32'd1;
                        mem_wdata <= word_q[{b_nxt, 3'b000} +: 8];
                    end
                end

                DONE: begin
                    mem_we    <= 1'b0;
                    s.s_ready <= 1'b0;
                end

                default: state <= FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader with a 16-byte instruction memory.
module tb_imem_loader;

    localparam logic [31:0] BASE = 32'h0040_0000;

    logic        CLK = 1'b0;
    logic        reset = 1'b1;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        cpu_reset;
    logic        done;
    logic        err;

    int npass  = 0;
    int ntotal = 0;

    imem_loader_if sif ();

    imem_loader #(
        .INSTADDR (BASE),
        .INSTSIZE (16),
        .FILL_BYTE(8'hFF)
    ) dut (
        .CLK      (CLK),
        .reset    (reset),
        .s        (sif),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .cpu_reset(cpu_reset),
        .done     (done),
        .err      (err)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntotal++;
        assert (obs === exp) npass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic chkb(input string tag, input logic obs, input logic exp);
        ntotal++;
        assert (obs === exp) npass++;
        else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    endtask

    task automatic reset_and_fill();
        sif.s_valid = 1'b0;
        sif.s_last  = 1'b0;
        reset = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        chkb("rst_we", mem_we, 1'b0);
        chk ("rst_addr", mem_addr, BASE);
        chk ("rst_wdata", 32'(mem_wdata), 32'h0000_00FF);
        chkb("rst_ready", sif.s_ready, 1'b0);
        chkb("rst_cpu_reset", cpu_reset, 1'b1);
        chkb("rst_done", done, 1'b0);
        chkb("rst_err", err, 1'b0);
        reset = 1'b0;
        for (int k = 0; k < 16; k++) begin
            @(negedge CLK);
            chkb("fill_we", mem_we, 1'b1);
            chk ("fill_addr", mem_addr, BASE + 32'(k));
            chk ("fill_wdata", 32'(mem_wdata), 32'h0000_00FF);
            chkb("fill_ready", sif.s_ready, 1'b0);
            chkb("fill_cpu_reset", cpu_reset, 1'b1);
        end
        @(negedge CLK);
        chkb("idle_ready", sif.s_ready, 1'b1);
        chkb("idle_we", mem_we, 1'b0);
        chkb("idle_cpu_reset", cpu_reset, 1'b1);
    endtask

    // Presents one word and returns at the negedge after its handshake edge.
    task automatic send(input logic [31:0] w, input logic l);
        int guard;
        guard = 0;
        sif.s_valid = 1'b1;
        sif.s_word  = w;
        sif.s_last  = l;
        while (sif.s_ready !== 1'b1 && guard < 50) begin
            @(negedge CLK);
            guard++;
        end
        chkb("hs_wait", guard < 50, 1'b1);
        @(negedge CLK);
        sif.s_valid = 1'b0;
        sif.s_last  = 1'b0;
    endtask

    task automatic expect_word(input int wn, input logic [31:0] w, input logic l);
        for (int b = 0; b < 4; b++) begin
            chkb("wr_we", mem_we, 1'b1);
            chk ("wr_addr", mem_addr, BASE + 32'(4 * wn + b));
            chk ("wr_data", 32'(mem_wdata), 32'(w[8*b +: 8]));
            chkb("wr_ready", sif.s_ready, 1'b0);
            @(negedge CLK);
        end
        chkb("post_we", mem_we, 1'b0);
        chkb("post_done", done, l);
        chkb("post_cpu_reset", cpu_reset, ~l);
        chkb("post_ready", sif.s_ready, ~l);
    endtask

    logic [31:0] words [5];

    initial begin
        sif.s_valid = 1'b0;
        sif.s_word  = '0;
        sif.s_last  = 1'b0;

        // Two-word program
        reset_and_fill();
        send(32'h2010_0005, 1'b0);
        expect_word(0, 32'h2010_0005, 1'b0);
        send(32'h0210_8020, 1'b1);
        expect_word(1, 32'h0210_8020, 1'b1);
        repeat (3) @(negedge CLK);
        chkb("done_hold", done, 1'b1);
        chkb("done_hold_we", mem_we, 1'b0);
        chkb("done_hold_ready", sif.s_ready, 1'b0);

        // Idle gap, then a one-word program
        reset_and_fill();
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            chkb("gap_we", mem_we, 1'b0);
            chkb("gap_ready", sif.s_ready, 1'b1);
        end
        send(32'hDEAD_BEEF, 1'b1);
        expect_word(0, 32'hDEAD_BEEF, 1'b1);

        // Overflow: fifth word into a four-word memory
        reset_and_fill();
        for (int i = 0; i < 4; i++) begin
            send(32'h1000_0000 + 32'(i), 1'b0);
            expect_word(i, 32'h1000_0000 + 32'(i), 1'b0);
        end
        chkb("ovf_err_before", err, 1'b0);
        send(32'hBAD0_0005, 1'b1);
        chkb("ovf_err", err, 1'b1);
        chkb("ovf_we", mem_we, 1'b0);
        chkb("ovf_done", done, 1'b1);
        chkb("ovf_cpu_reset", cpu_reset, 1'b0);
        @(negedge CLK);
        chkb("ovf_we_hold", mem_we, 1'b0);
        chkb("ovf_err_hold", err, 1'b1);

        // Reset in the middle of a word
        reset_and_fill();
        send(32'h1122_3344, 1'b0);
        @(negedge CLK);
        @(negedge CLK);
        chk ("mid_addr_b2", mem_addr, BASE + 32'd2);
        chk ("mid_data_b2", 32'(mem_wdata), 32'h0000_0022);
        reset = 1'b1;
        @(negedge CLK);
        chk ("mid_rst_addr", mem_addr, BASE);
        chkb("mid_rst_we", mem_we, 1'b0);
        chkb("mid_rst_err", err, 1'b0);
        chkb("mid_rst_done", done, 1'b0);
        chkb("mid_rst_cpu_reset", cpu_reset, 1'b1);

        // Continuous valid: ready must pulse once every five cycles
        reset_and_fill();
        words[0] = 32'hA1A2_A3A4;
        words[1] = 32'hB1B2_B3B4;
        words[2] = 32'hC1C2_C3C4;
        words[3] = 32'hD1D2_D3D4;
        words[4] = 32'hEEEE_EEEE;
        for (int c = 0; c < 20; c++) begin
            int ph;
            int wi;
            ph = c % 5;
            wi = (ph == 0) ? c / 5 : c / 5 + 1;
            sif.s_valid = 1'b1;
            sif.s_word  = words[wi];
            sif.s_last  = (wi == 3);
            chkb("stream_ready", sif.s_ready, ph == 0);
            chkb("stream_we", mem_we, ph != 0);
            if (ph != 0) begin
                chk("stream_addr", mem_addr, BASE + 32'(4 * (c / 5) + ph - 1));
                chk("stream_data", 32'(mem_wdata), 32'(words[c / 5][8*(ph-1) +: 8]));
            end
            @(negedge CLK);
        end
        sif.s_valid = 1'b0;
        sif.s_last  = 1'b0;
        chkb("stream_done", done, 1'b1);
        chkb("stream_err", err, 1'b0);
        chkb("stream_cpu_reset", cpu_reset, 1'b0);

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
